// File: rtl/eau_multi_if.sv
// rtl/eau_multi_if.sv - Command and status bundle for the multi-channel effective address unit
//
// Signals (master = LSU sequencer side, slave = eau_multi):
//   d     [DW-1:0]  byte data from bus
//   sel   [SW-1:0]  channel select for commands and for the output view
//   ld              sequential load into lane ptr[sel]
//   lw              direct lane write into lane `lane`
//   lane  [LW-1:0]  lane index for lw, lane 0 = LSB byte
//   inc, dec        post-increment / post-decrement of addr[sel]
//   clr             clear channel sel
//   oe              output enable for the address bus
//   valid           registered valid flag of the selected channel
//   wrap            one-cycle pulse after a wrapping inc/dec
// The tristated address bus q stays a plain port on eau_multi so the
// high-Z driver lives on a simple net rather than inside the bundle.
interface eau_multi_if #(
    parameter int DW  = 8,
    parameter int NB  = 2,
    parameter int NCH = 4
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    logic [DW-1:0] d;
    logic [SW-1:0] sel;
    logic          ld;
    logic          lw;
    logic [LW-1:0] lane;
    logic          inc;
    logic          dec;
    logic          clr;
    logic          oe;
    logic          valid;
    logic          wrap;

    modport master (
        output d, sel, ld, lw, lane, inc, dec, clr, oe,
        input  valid, wrap
    );

    modport slave (
        input  d, sel, ld, lw, lane, inc, dec, clr, oe,
        output valid, wrap
    );
endinterface

// File: rtl/eau_multi.sv
// rtl/eau_multi.sv - Multi-channel effective address unit with byte assembly and post inc/dec
//
// Ports:
//   clk   system clock, all state updates on rising edge
//   rst   asynchronous active-low reset
//   bus   eau_multi_if slave modport (commands, valid, wrap)
//   q     registered address of channel sel, high-Z when oe was low
//
// Each channel holds addr (AW bits), a lane pointer for sequential loads and
// a valid flag. Only channel sel changes on a given edge; one command applies
// per edge with priority clr > lw > ld > inc/dec.
module eau_multi #(
    parameter int DW  = 8,
    parameter int NB  = 2,
    parameter int NCH = 4
) (
    input  logic              clk,
    input  logic              rst,
    eau_multi_if.slave        bus,
    output logic [DW*NB-1:0]  q
);
    localparam int AW = DW * NB;
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;

    logic [AW-1:0]  addr [NCH];
    logic [LW-1:0]  ptr  [NCH];
    logic [NCH-1:0] vld;

    logic [AW-1:0]  cur_addr, nxt_addr;
    logic [LW-1:0]  cur_ptr, nxt_ptr;
    logic           cur_vld, nxt_vld, nxt_wrap;

    logic [AW-1:0]  q_reg;
    logic           q_en;
    logic           valid_reg;
    logic           wrap_reg;

    // Selected-channel view. Matching by loop means an out-of-range sel
    // (non power-of-two NCH) reads zero and writes nothing.
    always_comb begin
        cur_addr = '0;
        cur_ptr  = '0;
        cur_vld  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (SW'(i) == bus.sel) begin
                cur_addr = addr[i];
                cur_ptr  = ptr[i];
                cur_vld  = vld[i];
            end
        end
    end

    always_comb begin
        nxt_addr = cur_addr;
        nxt_ptr  = cur_ptr;
        nxt_vld  = cur_vld;
        nxt_wrap = 1'b0;
        if (bus.clr) begin
            nxt_addr = '0;
            nxt_ptr  = '0;
            nxt_vld  = 1'b0;
        end else if (bus.lw) begin
            // Lanes at or beyond NB match no iteration and are dropped.
            for (int j = 0; j < NB; j++) begin
                if (LW'(j) == bus.lane) begin
                    nxt_addr[j*DW +: DW] = bus.d;
                end
            end
        end else if (bus.ld) begin
            for (int j = 0; j < NB; j++) begin
                if (LW'(j) == cur_ptr) begin
                    nxt_addr[j*DW +: DW] = bus.d;
                end
            end
            // Top lane is tested first so that NB=1 always sets valid.
            if (cur_ptr == LW'(NB - 1)) begin
                nxt_ptr = '0;
                nxt_vld = 1'b1;
            end else begin
                nxt_ptr = cur_ptr + 1'b1;
                if (cur_ptr == '0) begin
                    nxt_vld = 1'b0;
                end
            end
        end else if (bus.inc && !bus.dec) begin
            nxt_addr = cur_addr + 1'b1;
            nxt_wrap = &cur_addr;
        end else if (bus.dec && !bus.inc) begin
            nxt_addr = cur_addr - 1'b1;
            nxt_wrap = (cur_addr == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                addr[i] <= '0;
                ptr[i]  <= '0;
            end
            vld       <= '0;
            q_reg     <= '0;
            q_en      <= 1'b0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (SW'(i) == bus.sel) begin
                    addr[i] <= nxt_addr;
                    ptr[i]  <= nxt_ptr;
                    vld[i]  <= nxt_vld;
                end
            end
            // Output stage samples the pre-update channel contents.
            q_reg     <= cur_addr;
            q_en      <= bus.oe;
            valid_reg <= cur_vld;
            wrap_reg  <= nxt_wrap;
        end
    end

    assign q         = q_en ? q_reg : {AW{1'bz}};
    assign bus.valid = valid_reg;
    assign bus.wrap  = wrap_reg;
endmodule

// File: tb/tb_eau_multi.sv
// tb/tb_eau_multi.sv - Directed self-checking bench for eau_multi
module tb_eau_multi;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    wire  [15:0] q;
    wire  [31:0] qw;
    logic [15:0] zz16;
    logic [31:0] zz32;

    eau_multi_if #(.DW(8), .NB(2), .NCH(4)) b ();
    eau_multi_if #(.DW(8), .NB(4), .NCH(2)) w ();

    eau_multi #(.DW(8), .NB(2), .NCH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b),
        .q   (q)
    );

    eau_multi #(.DW(8), .NB(4), .NCH(2)) u_wide (
        .clk (clk),
        .rst (rst),
        .bus (w),
        .q   (qw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b.ld = 0; b.lw = 0; b.inc = 0; b.dec = 0; b.clr = 0;
        w.ld = 0; w.lw = 0; w.inc = 0; w.dec = 0; w.clr = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        b.oe = 1; b.sel = 0; b.ld = 1; b.inc = 1; b.d = 8'h5A;
        cycle();
        if (q !== zz16) begin n_err++; $display("FAIL rst_q_z: got %h want %h", q, zz16); end
        n_vec++;
        idle();
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        n_vec++;
        if (q !== 16'h0000) begin n_err++; $display("FAIL rst_q: got %h want 0000", q); end
        n_vec++;
        if (b.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", b.valid); end
        n_vec++;
        if (b.wrap !== 1'b0) begin n_err++; $display("FAIL rst_wrap: got %b want 0", b.wrap); end
        b.oe = 0;
        cycle();
        n_vec++;
        if (q !== zz16) begin n_err++; $display("FAIL oe_off_z: got %h want %h", q, zz16); end
    endtask

    task automatic test_seq_load();
        b.oe = 1; b.sel = 1;
        b.ld = 1; b.d = 8'h34;
        cycle();
        b.d = 8'h12;
        cycle();
        n_vec++;
        if (q !== 16'h0034) begin n_err++; $display("FAIL ld_q_mid: got %h want 0034", q); end
        n_vec++;
        if (b.valid !== 1'b0) begin n_err++; $display("FAIL ld_valid_early: got %b want 0", b.valid); end
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h1234) begin n_err++; $display("FAIL ld_q: got %h want 1234", q); end
        n_vec++;
        if (b.valid !== 1'b1) begin n_err++; $display("FAIL ld_valid: got %b want 1", b.valid); end
        b.sel = 0;
        cycle();
        n_vec++;
        if (q !== 16'h0000) begin n_err++; $display("FAIL ch0_hold: got %h want 0000", q); end
    endtask

    task automatic test_wrap();
        b.oe = 1; b.sel = 2;
        b.lw = 1; b.lane = 1; b.d = 8'hFF;
        cycle();
        b.lane = 0;
        cycle();
        idle();
        b.inc = 1;
        cycle();
        n_vec++;
        if (b.wrap !== 1'b1) begin n_err++; $display("FAIL inc_wrap: got %b want 1", b.wrap); end
        n_vec++;
        if (q !== 16'hFFFF) begin n_err++; $display("FAIL inc_q_pre: got %h want ffff", q); end
        idle();
        cycle();
        n_vec++;
        if (b.wrap !== 1'b0) begin n_err++; $display("FAIL inc_wrap_pulse: got %b want 0", b.wrap); end
        n_vec++;
        if (q !== 16'h0000) begin n_err++; $display("FAIL inc_q: got %h want 0000", q); end
        b.dec = 1;
        cycle();
        n_vec++;
        if (b.wrap !== 1'b1) begin n_err++; $display("FAIL dec_wrap: got %b want 1", b.wrap); end
        idle();
        cycle();
        n_vec++;
        if (q !== 16'hFFFF) begin n_err++; $display("FAIL dec_q: got %h want ffff", q); end
        n_vec++;
        if (b.wrap !== 1'b0 || b.valid !== 1'b0) begin
            n_err++; $display("FAIL dec_flags: got wrap=%b valid=%b want 0 0", b.wrap, b.valid);
        end
    endtask

    task automatic test_priority();
        b.oe = 1; b.sel = 3;
        b.lw = 1; b.lane = 0; b.d = 8'hA0;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h00A0) begin n_err++; $display("FAIL prio_setup: got %h want 00a0", q); end
        b.clr = 1; b.ld = 1; b.inc = 1; b.d = 8'h77;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h0000) begin n_err++; $display("FAIL prio_clr: got %h want 0000", q); end
        b.ld = 1; b.inc = 1; b.d = 8'h55;
        cycle();
        n_vec++;
        if (b.wrap !== 1'b0) begin n_err++; $display("FAIL prio_ld_wrap: got %b want 0", b.wrap); end
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h0055) begin n_err++; $display("FAIL prio_ld: got %h want 0055", q); end
        b.ld = 1; b.d = 8'h66;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h6655 || b.valid !== 1'b1) begin
            n_err++; $display("FAIL prio_ptr: got %h valid=%b want 6655 valid=1", q, b.valid);
        end
        b.inc = 1; b.dec = 1;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h6655 || b.wrap !== 1'b0) begin
            n_err++; $display("FAIL prio_incdec: got %h wrap=%b want 6655 wrap=0", q, b.wrap);
        end
        b.lw = 1; b.lane = 1; b.d = 8'h00;
        b.sel = 1;
        b.lw = 0;
        cycle();
        n_vec++;
        if (q !== 16'h1234) begin n_err++; $display("FAIL hold_ch1: got %h want 1234", q); end
        b.sel = 2;
        cycle();
        n_vec++;
        if (q !== 16'hFFFF) begin n_err++; $display("FAIL hold_ch2: got %h want ffff", q); end
    endtask

    task automatic test_reset_midload();
        b.oe = 1; b.sel = 0;
        b.ld = 1; b.d = 8'hAA;
        cycle();
        idle();
        b.sel = 1;
        cycle();
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (q !== zz16) begin n_err++; $display("FAIL midrst_z: got %h want %h", q, zz16); end
        n_vec++;
        if (b.valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", b.valid); end
        cycle();
        rst = 1'b1;
        b.sel = 0;
        b.ld = 1; b.d = 8'h11;
        cycle();
        b.d = 8'h22;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (q !== 16'h2211) begin n_err++; $display("FAIL midrst_reload: got %h want 2211", q); end
        b.sel = 1;
        cycle();
        n_vec++;
        if (q !== 16'h0000) begin n_err++; $display("FAIL midrst_ch1_clr: got %h want 0000", q); end
    endtask

    task automatic test_wide();
        w.oe = 1; w.sel = 1;
        for (int i = 1; i <= 4; i++) begin
            w.ld = 1; w.d = 8'(i);
            cycle();
        end
        n_vec++;
        if (w.valid !== 1'b0) begin n_err++; $display("FAIL wide_valid_early: got %b want 0", w.valid); end
        idle();
        cycle();
        n_vec++;
        if (qw !== 32'h04030201) begin n_err++; $display("FAIL wide_q: got %h want 04030201", qw); end
        n_vec++;
        if (w.valid !== 1'b1) begin n_err++; $display("FAIL wide_valid: got %b want 1", w.valid); end
        w.ld = 1; w.d = 8'h99;
        cycle();
        idle();
        cycle();
        n_vec++;
        if (qw !== 32'h04030299 || w.valid !== 1'b0) begin
            n_err++; $display("FAIL wide_restart: got %h valid=%b want 04030299 valid=0", qw, w.valid);
        end
        w.oe = 0;
        cycle();
        n_vec++;
        if (qw !== zz32) begin n_err++; $display("FAIL wide_z: got %h want %h", qw, zz32); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        zz16 = 'z;
        zz32 = 'z;
        rst = 1'b0;
        b.d = 0; b.sel = 0; b.lane = 0; b.oe = 0;
        w.d = 0; w.sel = 0; w.lane = 0; w.oe = 0;
        idle();
        test_reset();
        test_seq_load();
        test_wrap();
        test_priority();
        test_reset_midload();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/eau_multi.md
Name: eau_multi

Overview:
- Parametrised multi-channel effective address unit for the LSU.
- Assembles AW-bit addresses from DW-bit bus bytes into NCH independent address registers.
- Bytes are written either by sequential load (auto-advancing lane pointer) or by direct lane write.
- Supports post-increment and post-decrement with a wrap flag; drives a registered, tristatable address bus onto the LSU address path.

Parameters:
- DW, 8, data bus byte width in bits.
- NB, 2, bytes per address; AW = DW*NB (derived localparam, not overridable).
- NCH, 4, number of address channels; SW = max(1, clog2(NCH)) (derived).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- d  in  DW  byte data from bus.
- sel  in  SW  channel select for all operations and for output.
- ld  in  1  sequential load: write d into lane ptr[sel] of channel sel.
- lw  in  1  direct lane write: write d into lane `lane` of channel sel.
- lane  in  max(1,clog2(NB))  lane index for lw; lane 0 = LSB byte.
- inc  in  1  add 1 to addr[sel], mod 2^AW.
- dec  in  1  subtract 1 from addr[sel], mod 2^AW.
- clr  in  1  synchronous clear of channel sel.
- oe  in  1  output enable for q.
- q  out  AW  registered address; high-Z when not enabled.
- valid  out  1  registered; valid[sel] as sampled at the edge.
- wrap  out  1  one-cycle pulse: the previous edge's inc/dec wrapped.

Behaviour:
- Reset (rst=0, asynchronous):
  - all addr[i]=0, ptr[i]=0, valid[i]=0.
  - q='z, valid=0, wrap=0.
  - Reset mid-load discards the partial address and returns ptr to 0.
- Per-channel state: addr[i] (AW bits), ptr[i] (lane pointer), valid[i].
- Only channel sel is modified on a given edge; other channels hold.
- Command priority on channel sel (one applies per edge): clr > lw > ld > inc/dec.
  - Lower-priority commands on the same edge are ignored (no side effects, wrap=0).
- clr: addr=0, ptr=0, valid=0.
- lw:
  - writes addr[lane*DW +: DW] = d.
  - ptr and valid unchanged.
  - lane >= NB is ignored (no change).
- ld:
  - writes addr[ptr*DW +: DW] = d.
  - ptr advances, wrapping from NB-1 to 0.
  - Writing lane NB-1 sets valid=1.
  - Writing lane 0 clears valid (a new load has started).
  - With NB=1, every ld sets valid.
- inc only: addr = addr+1; wrap=1 next cycle iff addr was all-ones.
- dec only: addr = addr-1; wrap=1 next cycle iff addr was 0.
- inc and dec together: no change, wrap=0.
- inc/dec do not change ptr or valid.
- q output:
  - on each edge, q <= oe ? addr[sel] : 'z.
  - the value is addr[sel] before that edge's update, giving one-cycle latency with pre-update data.
  - an update becomes visible on q two edges after its command if oe stays high.
- valid output: valid <= valid[sel] (pre-update), same timing as q, independent of oe.
- wrap output: registered pulse, high for exactly one cycle after a wrapping inc/dec, else 0.
- sel changing between cycles: q follows the newly selected channel at the next edge; no state is lost.
- X on control inputs during reset has no effect.

Test Plan:
1. Reset then hold oe=1, sel=0 for 2 cycles -> q=0x0000, valid=0, wrap=0; with oe=0, q='z.
2. sel=1, ld with d=0x34 then ld with d=0x12 -> addr[1]=0x1234; valid rises 2 edges after the second ld; q=0x1234 with oe=1; channel 0 still 0x0000.
3. sel=2, lw lane=1 d=0xFF, lw lane=0 d=0xFF, then inc -> addr[2]=0x0000 and wrap pulses one cycle; a following dec gives 0xFFFF with wrap pulsing again; valid stays 0 throughout.
4. Priority on one edge, sel=3 with addr=0x00A0: clr+ld+inc -> 0x0000; ld+inc with d=0x55, ptr=0 -> 0x0055, ptr=1, no increment; inc+dec -> unchanged.
5. Reset mid-load: ld d=0xAA on sel=0, assert rst=0 asynchronously between edges -> q='z immediately; after release, ld d=0x11, ld d=0x22 -> addr[0]=0x2211 (ptr restarted at 0).
6. Parameter sweep DW=8, NB=4, NCH=2: four ld bytes 0x01..0x04 -> q=0x04030201, valid=1; a fifth ld d=0x99 -> 0x04030299, valid=0.
